// File: rtl/isw_sched_pkg.sv
// Shared constants and types for the ISW masked-AND scheduler.
// The gadget is a fixed 3-share, 3-cycle ISW AND, so its geometry lives here
// rather than as top-level parameters.
package isw_sched_pkg;

  localparam int SHARES     = 3;
  localparam int RAND_W     = SHARES * (SHARES - 1) / 2;
  localparam int GAD_LAT    = 3;
  // One stage for the operand register in front of the gadget plus GAD_LAT
  // stages matching the gadget's own registers.
  localparam int TAG_STAGES = GAD_LAT + 1;
  // Wide enough for the largest supported requester count (4).
  localparam int ID_W       = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/isw_and_sched_rr_arbiter.sv
// Round-robin arbiter. The search starts at the pointer; the pointer moves to
// grant+1 only when the owner reports that the grant was actually used.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Pick the first asserted request at or after the pointer, wrapping around.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int off = 0; off < N; off++) begin
      w_idx = IW'((int'(r_ptr) + off) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

  // Pointer moves past the winner only on a used grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/isw_and_sched.sv
// Scheduler sharing one pipelined 3-share ISW AND gadget between NUM_REQ
// requesters. Each issue consumes exactly one randomness word; a tag pipeline
// returns every result to its owner GAD_LAT+1 cycles after the issue.
// A flush_req/flush_done handshake quiesces the gadget before reseeding.
// Build option: define ISW_SCHED_IDLE_ZERO_EN to drive the gadget inputs to
// zero in every cycle without an issue (default build holds them).
module isw_and_sched
  import isw_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SHARES-1:0] req_a,
  input  logic [NUM_REQ*SHARES-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [SHARES-1:0]         rsp_c,
  input  logic                      rnd_valid,
  input  logic [RAND_W-1:0]         rnd_data,
  output logic                      rnd_ready,
  output logic [SHARES-1:0]         gad_a,
  output logic [SHARES-1:0]         gad_b,
  output logic [RAND_W-1:0]         gad_r,
  input  logic [SHARES-1:0]         gad_c,
  input  logic                      flush_req,
  output logic                      flush_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                r_state;
  state_t                w_state_next;
  tag_t                  r_tag [TAG_STAGES];
  logic [TAG_STAGES-1:0] w_tag_valid;
  logic                  w_busy_next;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_grant_idx;
  logic                  w_issue;
  logic [SHARES-1:0]     w_req_a [NUM_REQ];
  logic [SHARES-1:0]     w_req_b [NUM_REQ];
  logic [SHARES-1:0]     r_gad_a;
  logic [SHARES-1:0]     r_gad_b;
  logic [RAND_W-1:0]     r_gad_r;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req       (req_valid),
    .i_advance   (w_issue),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < TAG_STAGES; gi++) begin : g_tag_valid
      assign w_tag_valid[gi] = r_tag[gi].valid;
    end
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_a[gi]   = req_a[gi*SHARES +: SHARES];
      assign w_req_b[gi]   = req_b[gi*SHARES +: SHARES];
      // Only a live tag can raise a response; stale gadget data never does.
      assign rsp_valid[gi] = r_tag[GAD_LAT].valid &&
                             (r_tag[GAD_LAT].id == ID_W'(gi)) && !reset;
    end
  endgenerate

  // While draining nothing enters stage 0, so the last stage empties this
  // cycle; the pipeline is empty next cycle when the earlier stages are empty.
  // This lands flush_done exactly one cycle after the final response.
  assign w_busy_next = |w_tag_valid[GAD_LAT-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus issue/flush outputs; issue needs RUN, no flush, fresh
  // randomness and at least one request.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    flush_done   = 1'b0;
    case (r_state)
      RUN: begin
        if (flush_req) begin
          w_state_next = DRAIN;
        end else begin
          w_issue = rnd_valid && (|req_valid) && !reset;
        end
      end
      DRAIN: begin
        if (!w_busy_next) begin
          w_state_next = HALT;
        end
      end
      HALT: begin
        flush_done = !reset;
        if (!flush_req) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  assign req_ready = w_issue ? w_grant : '0;
  assign rnd_ready = w_issue;

  // Tag pipeline travels alongside the operand register and gadget stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAG_STAGES; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0].valid <= w_issue;
      r_tag[0].id    <= ID_W'(w_grant_idx);
      for (int i = 1; i < TAG_STAGES; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Operand/randomness register feeding the gadget.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gad_a <= '0;
      r_gad_b <= '0;
      r_gad_r <= '0;
    end else if (w_issue) begin
      r_gad_a <= w_req_a[w_grant_idx];
      r_gad_b <= w_req_b[w_grant_idx];
      r_gad_r <= rnd_data;
    end
`ifdef ISW_SCHED_IDLE_ZERO_EN
    else begin
      // Zero between operations so shares of consecutive ops never meet.
      r_gad_a <= '0;
      r_gad_b <= '0;
      r_gad_r <= '0;
    end
`endif
  end

  assign gad_a = r_gad_a;
  assign gad_b = r_gad_b;
  assign gad_r = r_gad_r;
  assign rsp_c = gad_c;

endmodule

// File: tb/tb_isw_and_sched.sv
// Bench for isw_and_sched: behavioural 3-stage ISW gadget, directed scenarios
// and a randomized run checked against a queue-based reference model.
module tb_isw_and_sched;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*3-1:0] req_a;
  logic [NR*3-1:0] req_b;
  logic [NR-1:0] rsp_valid;
  logic [2:0]    rsp_c;
  logic          rnd_valid;
  logic [2:0]    rnd_data;
  logic          rnd_ready;
  logic [2:0]    gad_a;
  logic [2:0]    gad_b;
  logic [2:0]    gad_r;
  logic [2:0]    gad_c;
  logic          flush_req;
  logic          flush_done;

  int n_tests  = 0;
  int n_fail   = 0;
  int cycle_no = 0;

  isw_and_sched #(.NUM_REQ(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_c      (rsp_c),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .rnd_ready  (rnd_ready),
    .gad_a      (gad_a),
    .gad_b      (gad_b),
    .gad_r      (gad_r),
    .gad_c      (gad_c),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  // Behavioural ISW gadget: 3 registers, no reset, no stall.
  function automatic logic [2:0] isw(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] r);
    logic z01, z10, z02, z20, z12, z21;
    z01 = r[0];
    z10 = (r[0] ^ (a[0] & b[1])) ^ (a[1] & b[0]);
    z02 = r[1];
    z20 = (r[1] ^ (a[0] & b[2])) ^ (a[2] & b[0]);
    z12 = r[2];
    z21 = (r[2] ^ (a[1] & b[2])) ^ (a[2] & b[1]);
    return {(a[2] & b[2]) ^ z20 ^ z21,
            (a[1] & b[1]) ^ z10 ^ z12,
            (a[0] & b[0]) ^ z01 ^ z02};
  endfunction

  logic [2:0] g1 = '0, g2 = '0, g3 = '0;
  always @(posedge clk) begin
    g1 <= isw(gad_a, gad_b, gad_r);
    g2 <= g1;
    g3 <= g2;
  end
  assign gad_c = g3;

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic idle();
    req_valid = '0;
    rnd_valid = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    req_valid = 2'b11; rnd_valid = 1'b1; req_a = 6'b101011; req_b = 6'b110111;
    rnd_data = 3'b110;
    cyc();
    cyc();
    #2;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_tests++; if (rnd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_ready: got %b want 0", rnd_ready); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_tests++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    n_tests++; if ({gad_a, gad_b, gad_r} !== 9'd0) begin n_fail++; $display("FAIL reset_gad: got %b want 0", {gad_a, gad_b, gad_r}); end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] ea, eb, er;
    cyc();
    req_valid = 2'b01; req_a = {3'b000, 3'b001}; req_b = {3'b000, 3'b111};
    rnd_valid = 1'b1; rnd_data = 3'b101;
    #2;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    n_tests++; if (rnd_ready !== 1'b1) begin n_fail++; $display("FAIL single_rnd_ready: got %b want 1", rnd_ready); end
    cyc(); idle(); #2;
    n_tests++; if (gad_r !== 3'b101) begin n_fail++; $display("FAIL single_gad_r: got %b want 101", gad_r); end
    n_tests++; if (gad_a !== 3'b001 || gad_b !== 3'b111) begin n_fail++; $display("FAIL single_gad_ab: got %b/%b want 001/111", gad_a, gad_b); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early1: got %b want 00", rsp_valid); end
    cyc(); #2;
`ifdef ISW_SCHED_IDLE_ZERO_EN
    ea = 3'b000; eb = 3'b000; er = 3'b000;
`else
    ea = 3'b001; eb = 3'b111; er = 3'b101;
`endif
    n_tests++; if ({gad_a, gad_b, gad_r} !== {ea, eb, er}) begin n_fail++; $display("FAIL single_idle_gad: got %b want %b", {gad_a, gad_b, gad_r}, {ea, eb, er}); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early2: got %b want 00", rsp_valid); end
    cyc(); #2;
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early3: got %b want 00", rsp_valid); end
    cyc(); #2;
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp: got %b want 01", rsp_valid); end
    n_tests++; if ((^rsp_c) !== 1'b1) begin n_fail++; $display("FAIL single_rsp_c: got %b (xor %b) want xor 1", rsp_c, ^rsp_c); end
    cyc(); #2;
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_late: got %b want 00", rsp_valid); end
    $display("[TB] single issue a=001 b=111 r=101 done");
  endtask

  task automatic test_contention();
    logic [2:0] a0, a1, b0, b1;
    logic ec [4];
    logic [1:0] want;
    int consumed = 0;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      cyc();
      if (k < 4) begin
        a0 = 3'($urandom); a1 = 3'($urandom); b0 = 3'($urandom); b1 = 3'($urandom);
        req_valid = 2'b11; req_a = {a1, a0}; req_b = {b1, b0};
        rnd_valid = 1'b1; rnd_data = 3'($urandom);
        ec[k] = (k % 2 == 0) ? ((^a0) & (^b0)) : ((^a1) & (^b1));
      end else begin
        idle();
      end
      #2;
      if (k < 4) begin
        want = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_tests++; if (req_ready !== want) begin n_fail++; $display("FAIL contention_grant%0d: got %b want %b", k, req_ready, want); end
        if (rnd_ready === 1'b1) consumed++;
      end
      want = 2'b00;
      if (k >= 4 && k < 8) want = ((k - 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++; if (rsp_valid !== want) begin n_fail++; $display("FAIL contention_rsp%0d: got %b want %b", k, rsp_valid, want); end
      if (want != 2'b00) begin
        n_tests++; if ((^rsp_c) !== ec[k-4]) begin n_fail++; $display("FAIL contention_rsp_c%0d: got xor %b want %b", k, ^rsp_c, ec[k-4]); end
      end
    end
    n_tests++; if (consumed != 4) begin n_fail++; $display("FAIL contention_rnd_count: got %0d want 4", consumed); end
    $display("[TB] contention: 4 issues, %0d rnd words consumed", consumed);
  endtask

  task automatic test_starvation();
    logic [2:0] a0, a1, b0, b1;
    logic ec [2];
    logic [1:0] want;
    for (int k = 0; k <= 10; k++) begin
      cyc();
      idle();
      if (k <= 5) begin
        a0 = 3'($urandom); a1 = 3'($urandom); b0 = 3'($urandom); b1 = 3'($urandom);
        req_valid = 2'b11; req_a = {a1, a0}; req_b = {b1, b0};
        rnd_valid = (k >= 4); rnd_data = 3'($urandom);
        if (k == 4) ec[0] = (^a0) & (^b0);
        if (k == 5) ec[1] = (^a1) & (^b1);
      end
      #2;
      if (k <= 5) begin
        want = (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
        n_tests++; if (req_ready !== want) begin n_fail++; $display("FAIL starve_ready%0d: got %b want %b", k, req_ready, want); end
        n_tests++; if (rnd_ready !== (k >= 4)) begin n_fail++; $display("FAIL starve_rnd_ready%0d: got %b want %b", k, rnd_ready, (k >= 4)); end
      end
      want = (k == 8) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00;
      n_tests++; if (rsp_valid !== want) begin n_fail++; $display("FAIL starve_rsp%0d: got %b want %b", k, rsp_valid, want); end
      if (want != 2'b00) begin
        n_tests++; if ((^rsp_c) !== ec[k-8]) begin n_fail++; $display("FAIL starve_rsp_c%0d: got xor %b want %b", k, ^rsp_c, ec[k-8]); end
      end
    end
    $display("[TB] starvation: issue resumed with pointer intact");
  endtask

  task automatic test_flush();
    logic [2:0] a0, b0;
    logic ec [4];
    logic [1:0] want;
    logic       want_issue;
    for (int k = 0; k <= 15; k++) begin
      cyc();
      idle();
      a0 = 3'($urandom); b0 = 3'($urandom);
      req_a = {3'($urandom), a0}; req_b = {3'($urandom), b0}; rnd_data = 3'($urandom);
      if (k <= 10) begin
        req_valid = 2'b01; rnd_valid = 1'b1;
        flush_req = (k >= 3 && k <= 8);
      end
      want_issue = (k <= 2) || (k == 10);
      if (k <= 2) ec[k] = (^a0) & (^b0);
      if (k == 10) ec[3] = (^a0) & (^b0);
      #2;
      if (k <= 10) begin
        want = want_issue ? 2'b01 : 2'b00;
        n_tests++; if (req_ready !== want) begin n_fail++; $display("FAIL flush_ready%0d: got %b want %b", k, req_ready, want); end
        n_tests++; if (rnd_ready !== want_issue) begin n_fail++; $display("FAIL flush_rnd_ready%0d: got %b want %b", k, rnd_ready, want_issue); end
      end
      n_tests++; if (flush_done !== (k >= 7 && k <= 9)) begin n_fail++; $display("FAIL flush_done%0d: got %b want %b", k, flush_done, (k >= 7 && k <= 9)); end
      want = (k >= 4 && k <= 6) || (k == 14) ? 2'b01 : 2'b00;
      n_tests++; if (rsp_valid !== want) begin n_fail++; $display("FAIL flush_rsp%0d: got %b want %b", k, rsp_valid, want); end
      if (want != 2'b00) begin
        n_tests++; if ((^rsp_c) !== ec[(k == 14) ? 3 : k - 4]) begin n_fail++; $display("FAIL flush_rsp_c%0d: got xor %b want %b", k, ^rsp_c, ec[(k == 14) ? 3 : k - 4]); end
      end
    end
    $display("[TB] flush: drained 3 ops, halted, resumed");
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k <= 10; k++) begin
      cyc();
      idle();
      req_a = 6'($urandom); req_b = 6'($urandom); rnd_data = 3'($urandom);
      if (k <= 3) begin
        req_valid = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b11;
        rnd_valid = 1'b1;
      end
      reset = (k == 2 || k == 3);
      #2;
      if (k == 0) begin
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_grant0: got %b want 01", req_ready); end
      end
      if (k == 1) begin
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL midrst_grant1: got %b want 10", req_ready); end
      end
      if (k == 2 || k == 3) begin
        n_tests++; if ({req_ready, rnd_ready, flush_done} !== 4'b0000) begin n_fail++; $display("FAIL midrst_outputs%0d: got %b want 0000", k, {req_ready, rnd_ready, flush_done}); end
      end
      if (k == 3) begin
        n_tests++; if ({gad_a, gad_b, gad_r} !== 9'd0) begin n_fail++; $display("FAIL midrst_gad: got %b want 0", {gad_a, gad_b, gad_r}); end
      end
      if (k >= 2) begin
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_rsp%0d: got %b want 00", k, rsp_valid); end
      end
    end
    reset = 1'b0;
    $display("[TB] reset mid-flight: in-flight ops discarded");
  endtask

  typedef struct {
    int   due;
    int   id;
    logic c;
  } exp_t;

  task automatic test_random();
    exp_t       q[$];
    exp_t       e;
    int         ptr_m = 0;
    int         g;
    logic       issue;
    logic [1:0] rv, want_ready, want_rsp;
    logic [2:0] a[NR], b[NR];
    logic [2:0] r;
    logic [2:0] exp_a = '0, exp_b = '0, exp_r = '0;
    do_reset();
    for (int k = 0; k < 406; k++) begin
      cyc();
      if (k < 400) begin
        rv = 2'($urandom);
        for (int i = 0; i < NR; i++) begin
          a[i] = 3'($urandom); b[i] = 3'($urandom);
        end
        r = 3'($urandom);
        req_valid = rv; req_a = {a[1], a[0]}; req_b = {b[1], b[0]};
        rnd_valid = ($urandom_range(0, 3) != 0); rnd_data = r; flush_req = 1'b0;
      end else begin
        idle();
        rv = 2'b00;
      end
      #2;
      // Gadget inputs reflect what was settled at the previous edge.
      n_tests++; if ({gad_a, gad_b, gad_r} !== {exp_a, exp_b, exp_r}) begin n_fail++; $display("FAIL rand_gad c%0d: got %b want %b", cycle_no, {gad_a, gad_b, gad_r}, {exp_a, exp_b, exp_r}); end
      // Expected grant: first requester at or after the pointer.
      issue = 1'b0; g = 0; want_ready = '0;
      if (rnd_valid) begin
        for (int off = 0; off < NR; off++) begin
          if (!issue && rv[(ptr_m + off) % NR]) begin
            issue = 1'b1;
            g = (ptr_m + off) % NR;
          end
        end
      end
      if (issue) want_ready[g] = 1'b1;
      n_tests++; if (req_ready !== want_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", cycle_no, req_ready, want_ready); end
      n_tests++; if (rnd_ready !== issue) begin n_fail++; $display("FAIL rand_rnd_ready c%0d: got %b want %b", cycle_no, rnd_ready, issue); end
      n_tests++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rand_flush_done c%0d: got %b want 0", cycle_no, flush_done); end
      want_rsp = '0;
      if (q.size() > 0 && q[0].due == cycle_no) begin
        e = q.pop_front();
        want_rsp[e.id] = 1'b1;
        n_tests++; if ((^rsp_c) !== e.c) begin n_fail++; $display("FAIL rand_rsp_c c%0d: got xor %b want %b", cycle_no, ^rsp_c, e.c); end
      end
      n_tests++; if (rsp_valid !== want_rsp) begin n_fail++; $display("FAIL rand_rsp c%0d: got %b want %b", cycle_no, rsp_valid, want_rsp); end
      if (issue) begin
        e.due = cycle_no + 4; e.id = g; e.c = (^a[g]) & (^b[g]);
        q.push_back(e);
        ptr_m = (g + 1) % NR;
        exp_a = a[g]; exp_b = b[g]; exp_r = r;
      end else begin
`ifdef ISW_SCHED_IDLE_ZERO_EN
        exp_a = '0; exp_b = '0; exp_r = '0;
`endif
      end
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d pending want 0", q.size()); end
    $display("[TB] random: 400 cycles checked");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    rnd_valid = 1'b0; rnd_data = '0; flush_req = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
